fb_scanout: RTL and testbench
=============================

// Module: fb_scanout
// PURPOSE
//  Reads the 1bpp framebuffer that SM kernels rasterise into memory and streams it out as
//  pixels in raster order (x fastest), one pixel per handshake. Sits downstream of the
//  streaming_multiprocessor, on a read port of the shared line memory (128-byte lines).
//  Replaces testbench backdoor dumps of the framebuffer with a real hardware consumer.
//  Double-buffers memory lines so pixel output is continuous while the next line is fetched.
// PARAMETERS
//  FB_WIDTH   64        pixels per row; multiple of 8, FB_WIDTH/8 divides 128
//  FB_HEIGHT  64        rows per frame; FB_WIDTH*FB_HEIGHT/1024 must be an integer >=1
//  FB_BASE    32'h2000  byte base address; 128-byte aligned
//  LINE_BITS  1024      memory line width (128 bytes)
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous, active-high reset
//  start          in   1          pulse: begin one frame (ignored unless IDLE)
//  busy           out  1          high from accepted start until frame_done
//  frame_done     out  1          1-cycle pulse after last pixel handshake
//  mem_req_valid  out  1          line read request
//  mem_req_ready  in   1          memory accepts request
//  mem_req_addr   out  32         line byte address (low 7 bits zero)
//  mem_rsp_valid  in   1          read data returned (one cycle, no backpressure)
//  mem_rsp_data   in   LINE_BITS  line data; byte b at bits [8b+7:8b]
//  px_valid       out  1          pixel available
//  px_ready       in   1          consumer accepts pixel
//  px_data        out  1          pixel value
//  px_x           out  $clog2(FB_WIDTH)   column
//  px_y           out  $clog2(FB_HEIGHT)  row
//  px_sof/px_eol/px_eof out 1 each  first pixel of frame / last of row / last of frame
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, both buffers invalid, outstanding flag cleared.
//  - Pixel (x,y): byte addr FB_BASE + y*(FB_WIDTH/8) + x/8, bit x%8 of that byte.
//  - NLINES = FB_WIDTH*FB_HEIGHT/1024; line k addr = FB_BASE + 128*k, fetched k=0..NLINES-1.
//  - FSM: IDLE -start-> FETCH0 (req line 0) -rsp-> STREAM -last px accepted-> DONE -> IDLE.
//  - DONE lasts one cycle, asserts frame_done; busy drops same cycle.
//  - At most one request outstanding; mem_req_valid held with stable addr until mem_req_ready.
//  - Prefetch: in STREAM, line k+1 requested as soon as the other buffer is free and
//    k+1<NLINES; buffer freed on handshake of its last pixel.
//  - Latency: start at cycle T -> mem_req_valid at T+1; rsp at cycle R -> px_valid at R+1.
//  - px_valid drops (bubble) only if the next line has not yet returned; no pixel skipped.
//  - px_* stable while px_valid && !px_ready (AXI-stream rules); px_valid not retracted.
//  - px_eol when x==FB_WIDTH-1; px_eof when also y==FB_HEIGHT-1; px_sof at (0,0).
//  - mem_rsp_valid with no outstanding request: ignored (covers rsp after reset).
//  - start while busy: ignored, no effect on current frame.
//  - Reset mid-frame: immediate abort, no frame_done; late responses dropped as above.
//  - Pixel counters wrap only by returning to IDLE; x,y widths exact ($clog2).
// STRUCTURE
//  - simt_pkg: scanout_state_t {SO_IDLE, SO_FETCH0, SO_STREAM, SO_DONE}; constants
//    FB_LINE_BYTES=128, FB_LINE_SHIFT=7 shared with memory model.
//  - Sub-module fb_line_buffer: 2 x LINE_BITS entries, valid bits, write-on-rsp,
//    bit-select read by (buf_sel, bit offset); top holds FSM, counters, handshakes.
// TESTING
//  - Clear FB, mem byte 0x2000=0x01 -> only pixel (0,0)=1 of 4096; px_sof on it.
//  - Byte 0x21FF=0x80 -> only pixel (63,63)=1, coincident with px_eol and px_eof.
//  - Full frame, px_ready=1, 0-latency memory -> 4096 pixels, no bubbles after first,
//    exactly 4 requests at 0x2000,0x2080,0x2100,0x2180, one frame_done.
//  - Random px_ready (50%) + memory latency 0..20 -> pixel stream matches golden image
//    (torus frame bitmap), outputs stable under stall, one outstanding request max.
//  - start pulsed at pixel 1000 mid-frame -> ignored; still 4096 pixels, one frame_done.
//  - rst at pixel 2000 with request in flight, rsp arrives 3 cycles later -> ignored;
//    outputs 0, next start yields a correct full frame from line 0x2000.

Source files
------------

// File: rtl/simt_pkg.sv
// Shared SIMT definitions: scanout FSM states and memory line geometry,
// common to the scanout engine and the line-memory model.
package simt_pkg;

  typedef enum logic [1:0] {
    SO_IDLE   = 2'd0,
    SO_FETCH0 = 2'd1,
    SO_STREAM = 2'd2,
    SO_DONE   = 2'd3
  } scanout_state_t;

  localparam int FB_LINE_BYTES = 128;
  localparam int FB_LINE_SHIFT = 7;

endpackage

// File: rtl/fb_line_buffer.sv
// Two-entry memory-line buffer for framebuffer scanout: whole-line write from a
// read response, per-entry valid bits, single-bit read by (entry, bit offset).
module fb_line_buffer #(
  parameter int LINE_BITS = 1024,
  parameter int OFF_W     = $clog2(LINE_BITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic                 clr_en,
  input  logic                 clr_sel,
  input  logic                 rd_sel,
  input  logic [OFF_W-1:0]     rd_off,
  output logic                 rd_bit,
  output logic [1:0]           line_valid
);

  logic [LINE_BITS-1:0] lines [2];

  // NOTE: line storage is deliberately not reset; line_valid alone says whether an entry holds data.
  always_ff @(posedge clk) begin
    if (wr_en) lines[wr_sel] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= '0;
    end else begin
      if (clr_en) line_valid[clr_sel] <= 1'b0;
      if (wr_en)  line_valid[wr_sel]  <= 1'b1;
    end
  end

  assign rd_bit = lines[rd_sel][rd_off];

endmodule

// File: rtl/fb_scanout.sv
// Streams a 1bpp framebuffer from line memory as raster-order pixels, fetching
// the next memory line into the spare buffer while the current one drains.
module fb_scanout
  import simt_pkg::*;
#(
  parameter int          FB_WIDTH  = 64,
  parameter int          FB_HEIGHT = 64,
  parameter logic [31:0] FB_BASE   = 32'h2000,
  parameter int          LINE_BITS = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [31:0]                  mem_req_addr,
  input  logic                         mem_rsp_valid,
  input  logic [LINE_BITS-1:0]         mem_rsp_data,
  output logic                         px_valid,
  input  logic                         px_ready,
  output logic                         px_data,
  output logic [$clog2(FB_WIDTH)-1:0]  px_x,
  output logic [$clog2(FB_HEIGHT)-1:0] px_y,
  output logic                         px_sof,
  output logic                         px_eol,
  output logic                         px_eof
);

  localparam int NLINES = FB_WIDTH * FB_HEIGHT / LINE_BITS;
  localparam int X_W    = $clog2(FB_WIDTH);
  localparam int Y_W    = $clog2(FB_HEIGHT);
  localparam int OFF_W  = $clog2(LINE_BITS);
  localparam int FL_W   = $clog2(NLINES + 1);

  scanout_state_t  state;
  logic            outstanding;
  logic            rd_buf;
  logic            wr_buf;
  logic [OFF_W-1:0] rd_off;
  logic [FL_W-1:0] fetch_line;
  logic [1:0]      line_valid;
  logic            rd_bit;

  logic rsp_accept, px_fire, last_in_line, at_eol, at_eof, want_req;

  // The linear pixel index modulo LINE_BITS is exactly the bit offset inside a line,
  // so rd_off walks the buffer while x/y only feed the sideband outputs.
  assign rsp_accept   = outstanding && mem_rsp_valid;
  assign px_fire      = px_valid && px_ready;
  assign last_in_line = (rd_off == OFF_W'(LINE_BITS - 1));
  assign at_eol       = (px_x == X_W'(FB_WIDTH - 1));
  assign at_eof       = at_eol && (px_y == Y_W'(FB_HEIGHT - 1));
  assign want_req     = (state == SO_STREAM) && !mem_req_valid && !outstanding &&
                        !line_valid[wr_buf] && (fetch_line < FL_W'(NLINES));

  assign busy       = (state == SO_FETCH0) || (state == SO_STREAM);
  assign frame_done = (state == SO_DONE);
  assign px_valid   = (state == SO_STREAM) && line_valid[rd_buf];
  assign px_data    = px_valid && rd_bit;
  assign px_sof     = px_valid && (px_x == '0) && (px_y == '0);
  assign px_eol     = px_valid && at_eol;
  assign px_eof     = px_valid && at_eof;

  fb_line_buffer #(.LINE_BITS(LINE_BITS), .OFF_W(OFF_W)) u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (rsp_accept),
    .wr_sel     (wr_buf),
    .wr_data    (mem_rsp_data),
    .clr_en     (px_fire && last_in_line),
    .clr_sel    (rd_buf),
    .rd_sel     (rd_buf),
    .rd_off     (rd_off),
    .rd_bit     (rd_bit),
    .line_valid (line_valid)
  );

  // NOTE: non-blocking assignments in clocked blocks so every update reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SO_IDLE;
      outstanding   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      fetch_line    <= '0;
      rd_buf        <= 1'b0;
      wr_buf        <= 1'b0;
      rd_off        <= '0;
      px_x          <= '0;
      px_y          <= '0;
    end else begin
      case (state)
        SO_IDLE: begin
          rd_buf     <= 1'b0;
          wr_buf     <= 1'b0;
          rd_off     <= '0;
          px_x       <= '0;
          px_y       <= '0;
          fetch_line <= '0;
          if (start) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= FB_BASE;
            fetch_line    <= FL_W'(1);
            state         <= SO_FETCH0;
          end
        end
        SO_FETCH0: if (rsp_accept) state <= SO_STREAM;
        SO_STREAM: if (px_fire && at_eof) state <= SO_DONE;
        default:   state <= SO_IDLE;
      endcase

      if (mem_req_valid && mem_req_ready) begin
        mem_req_valid <= 1'b0;
        outstanding   <= 1'b1;
      end
      if (rsp_accept) begin
        outstanding <= 1'b0;
        wr_buf      <= ~wr_buf;
      end
      if (want_req) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= FB_BASE + (32'(fetch_line) << FB_LINE_SHIFT);
        fetch_line    <= fetch_line + FL_W'(1);
      end

      if (px_fire) begin
        rd_off <= rd_off + OFF_W'(1);
        if (last_in_line) rd_buf <= ~rd_buf;
        if (at_eol) begin
          px_x <= '0;
          if (!at_eof) px_y <= px_y + Y_W'(1);
        end else begin
          px_x <= px_x + X_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: a line-memory model answers requests, expected
// pixels are queued at frame start and a monitor pops them on each pixel handshake.
module tb_fb_scanout;
  localparam int          W    = 64;
  localparam int          H    = 64;
  localparam int          NPIX = W * H;
  localparam int          LB   = 1024;
  localparam logic [31:0] BASE = 32'h2000;

  typedef struct packed {
    logic       d;
    logic [5:0] x;
    logic [5:0] y;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst, start, busy, frame_done;
  logic          mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0]   mem_req_addr;
  logic [LB-1:0] mem_rsp_data;
  logic          px_valid, px_ready, px_data, px_sof, px_eol, px_eof;
  logic [5:0]    px_x, px_y;

  int   checks = 0, failures = 0;
  int   done_cnt = 0, frame_pix = 0, bubbles = 0;
  bit   rand_mode = 0, hold_rsp = 0, resp_pending = 0;
  int   lat_max = 0;
  pix_t exp_q[$];
  logic [31:0] req_log[$];
  bit   img [H][W];
  logic [7:0] mem_bytes [512];

  always #5 clk = ~clk;

  fb_scanout dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data), .px_x(px_x), .px_y(px_y),
    .px_sof(px_sof), .px_eol(px_eol), .px_eof(px_eof)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 1'b0;
    for (int i = 0; i < 512; i++) mem_bytes[i] = 8'h00;
  endtask

  // Ring (torus cross-section) plus an off-axis mark so mirror/bit-order errors show.
  task automatic build_torus();
    int dx, dy, r2;
    logic [7:0] byte_v;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        dx = x - 30; dy = y - 33; r2 = dx * dx + dy * dy;
        img[y][x] = (r2 >= 81) && (r2 <= 400);
      end
    img[2][5] = 1'b1;
    for (int y = 0; y < H; y++)
      for (int xb = 0; xb < W / 8; xb++) begin
        for (int b = 0; b < 8; b++) byte_v[b] = img[y][xb * 8 + b];
        mem_bytes[y * (W / 8) + xb] = byte_v;
      end
  endtask

  task automatic push_expected();
    pix_t p;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        p.d   = img[y][x];
        p.x   = 6'(x);
        p.y   = 6'(y);
        p.sof = (x == 0) && (y == 0);
        p.eol = (x == W - 1);
        p.eof = (x == W - 1) && (y == H - 1);
        exp_q.push_back(p);
      end
  endtask

  task automatic check_reqs(input string tag);
    logic [31:0] a;
    check({tag, "_req_count"}, req_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      a = (k < req_log.size()) ? req_log[k] : 32'hFFFF_FFFF;
      check($sformatf("%s_req_addr%0d", tag, k), a, BASE + 32'(128 * k));
    end
  endtask

  task automatic run_frame(input string tag, input int mid_start);
    int  d0 = done_cnt;
    int  cyc = 0;
    bit  pulsed = 0;
    exp_q.delete(); req_log.delete();
    push_expected();
    frame_pix = 0; bubbles = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check({tag, "_req_latency"}, {mem_req_valid, mem_req_addr}, {1'b1, BASE});
    check({tag, "_busy"}, busy, 1);
    while (done_cnt == d0 && cyc < 30000) begin
      @(posedge clk); #1;
      cyc++;
      start = (mid_start >= 0) && !pulsed && (frame_pix >= mid_start);
      if (start) pulsed = 1;
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    check({tag, "_frame_done_count"}, done_cnt - d0, 1);
    check({tag, "_pixels"}, frame_pix, NPIX);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  // Line-memory model: one request at a time, optional ready delay and latency.
  initial begin : mem_model
    logic [31:0]   a;
    logic [LB-1:0] line;
    int            lat, off;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !rst) begin
        if (rand_mode) repeat ($urandom_range(0, 3)) @(negedge clk);
        if (mem_req_valid && !rst) begin
          a = mem_req_addr;
          mem_req_ready = 1'b1;
          @(posedge clk); #1;
          mem_req_ready = 1'b0;
          resp_pending  = 1'b1;
          req_log.push_back(a);
          lat = rand_mode ? $urandom_range(0, lat_max) : 0;
          repeat (lat) begin @(posedge clk); #1; end
          while (hold_rsp) begin @(posedge clk); #1; end
          for (int b = 0; b < 128; b++) begin
            off = int'(a - BASE) + b;
            line[8 * b +: 8] = (off >= 0 && off < 512) ? mem_bytes[off] : 8'h00;
          end
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = line;
          @(posedge clk); #1;
          mem_rsp_valid = 1'b0;
          resp_pending  = 1'b0;
        end
      end
    end
  end

  initial begin : ready_drv
    px_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      px_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    pix_t cur, prev, e;
    bit   prev_stall = 0, prev_rst = 1, started = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur.d = px_data; cur.x = px_x; cur.y = px_y;
      cur.sof = px_sof; cur.eol = px_eol; cur.eof = px_eof;
      if (!rst && !prev_rst && prev_stall) begin
        check("stall_valid_held", px_valid, 1);
        check("stall_fields_stable", cur, prev);
      end
      if (!rst) begin
        if (px_valid && px_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", px_x, px_y);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("pixel_%0d_%0d", e.x, e.y), cur, e);
          end
          frame_pix++;
        end
        if (px_valid) started = 1;
        if (busy && started && !px_valid) bubbles++;
        if (frame_done) begin
          done_cnt++;
          check("queue_empty_at_done", exp_q.size(), 0);
          started = 0;
        end
        if (mem_req_valid) check("one_outstanding", resp_pending, 0);
      end else begin
        started = 0;
      end
      prev_stall = px_valid && !px_ready;
      prev       = cur;
      prev_rst   = rst;
    end
  end

  initial begin : stim
    int d0, cyc;
    rst = 1'b1; start = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_req", {mem_req_valid, mem_req_addr}, 0);
    check("rst_px", {px_valid, px_data, px_x, px_y, px_sof, px_eol, px_eof}, 0);
    @(posedge clk); #1 rst = 1'b0;

    clear_all(); mem_bytes[0] = 8'h01; img[0][0] = 1'b1;
    run_frame("first_px", -1);

    clear_all(); mem_bytes[511] = 8'h80; img[63][63] = 1'b1;
    run_frame("last_px", -1);

    clear_all(); build_torus();
    run_frame("fast", -1);
    check("fast_bubbles", bubbles, 0);
    check_reqs("fast");

    rand_mode = 1; lat_max = 20;
    run_frame("random", -1);
    rand_mode = 0; lat_max = 0;

    run_frame("mid_start", 1000);
    check_reqs("mid_start");

    // Abort with line 2 held in flight, then let its response arrive after reset.
    exp_q.delete(); push_expected(); frame_pix = 0; d0 = done_cnt; cyc = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (frame_pix < 2000 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (frame_pix >= 500) hold_rsp = 1'b1;
    end
    check("abort_req_in_flight", resp_pending, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 hold_rsp = 1'b0;
    cyc = 0;
    while (resp_pending && cyc < 50) begin @(negedge clk); cyc++; end
    repeat (4) @(negedge clk);
    check("abort_rsp_delivered", resp_pending, 0);
    check("abort_busy", busy, 0);
    check("abort_req", mem_req_valid, 0);
    check("abort_px", {px_valid, px_data, px_x, px_y, px_sof, px_eol, px_eof}, 0);
    check("abort_no_done", done_cnt - d0, 0);

    run_frame("after_rst", -1);
    check_reqs("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
